// File: rtl/rename_resolver_nway.sv
// N-wide rename requester and intra-group RAW resolver between decode and dispatch.
// Holds one group through IDLE -> QUERY -> OUT, with retry on rename-table exhaustion.
module rename_resolver_nway #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned REG_W     = 6,
  parameter int unsigned PAYLOAD_W = 96
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         branch_resolve,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH*PAYLOAD_W-1:0]   in_payload,
  input  logic [WIDTH*3*REG_W-1:0]     in_regs,
  input  logic [WIDTH-1:0]             in_writes,
  input  logic [WIDTH-1:0]             in_jumps,
  output logic                         q_valid,
  output logic [WIDTH-1:0]             q_rename,
  output logic [WIDTH*3*REG_W-1:0]     q_regs,
  output logic                         q_tag,
  input  logic                         q_ack,
  input  logic                         q_full,
  input  logic [WIDTH*3*REG_W-1:0]     q_map,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH*PAYLOAD_W-1:0]   out_payload,
  output logic [WIDTH*4*REG_W-1:0]     out_regs,
  output logic [WIDTH-1:0]             out_tag,
  output logic                         stall
);

  localparam int unsigned SW = 3 * REG_W;
  localparam int unsigned OW = 4 * REG_W;

  if (WIDTH == 0 || WIDTH > 8 || XLEN == 0) begin : g_param_check
    $error("rename_resolver_nway: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, QUERY, OUT} state_e;

  state_e                       state_q;
  logic                         tag_active_q, tag_active_d;
  logic [WIDTH*PAYLOAD_W-1:0]   payload_q;
  logic [WIDTH-1:0]             writes_q, jumps_q;
  logic                         q_valid_q, q_tag_q;
  logic [WIDTH-1:0]             q_rename_q, q_rename_d;
  logic [WIDTH*SW-1:0]          q_regs_q;
  logic                         out_valid_q;
  logic [WIDTH*PAYLOAD_W-1:0]   out_payload_q;
  logic [WIDTH*OW-1:0]          out_regs_q, out_regs_d;
  logic [WIDTH-1:0]             out_tag_q, out_tag_d;

  logic accept, out_hs, ack_ok;

  assign in_ready = ((state_q == IDLE) || (state_q == OUT && out_ready))
                    && !(tag_active_q && |in_jumps) && !flush;
  assign accept   = in_valid && in_ready;
  assign out_hs   = (state_q == OUT) && out_ready && !flush;
  assign ack_ok   = (state_q == QUERY) && q_ack && !q_full && !flush;

  assign q_valid     = q_valid_q;
  assign q_rename    = q_rename_q;
  assign q_regs      = q_regs_q;
  assign q_tag       = q_tag_q;
  assign out_valid   = out_valid_q;
  assign out_payload = out_payload_q;
  assign out_regs    = out_regs_q;
  assign out_tag     = out_tag_q;
  assign stall       = (state_q == QUERY) || (state_q == OUT && !out_ready);

  always_comb begin
    q_rename_d = '0;
    for (int unsigned j = 0; j < WIDTH; j++) begin
      q_rename_d[j] = in_writes[j] && (in_regs[j*SW + 2*REG_W +: REG_W] != '0);
    end
  end

  // Ascending scan over older slots so the youngest matching writer wins.
  always_comb begin
    logic [REG_W-1:0] rd, rs1, rs2, rn, src1, src2, prd;
    logic             older_jump;
    out_regs_d = '0;
    out_tag_d  = '0;
    for (int unsigned j = 0; j < WIDTH; j++) begin
      rd         = q_regs_q[j*SW + 2*REG_W +: REG_W];
      rs2        = q_regs_q[j*SW + REG_W +: REG_W];
      rs1        = q_regs_q[j*SW +: REG_W];
      rn         = (writes_q[j] && rd != '0) ? q_map[j*SW + 2*REG_W +: REG_W] : '0;
      src2       = q_map[j*SW + REG_W +: REG_W];
      src1       = q_map[j*SW +: REG_W];
      older_jump = 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        prd = q_regs_q[i*SW + 2*REG_W +: REG_W];
        if (i < j) begin
          if (writes_q[i] && prd != '0) begin
            if (prd == rs1) src1 = q_map[i*SW + 2*REG_W +: REG_W];
            if (prd == rs2) src2 = q_map[i*SW + 2*REG_W +: REG_W];
          end
          if (jumps_q[i]) older_jump = 1'b1;
        end
      end
      out_regs_d[j*OW +: OW] = {rn, rd, src2, src1};
      out_tag_d[j] = jumps_q[j] ? 1'b0 : (older_jump ? 1'b1 : tag_active_q);
    end
  end

  // A jump-group handshake outranks a same-cycle resolve.
  always_comb begin
    tag_active_d = tag_active_q;
    if (flush)                      tag_active_d = 1'b0;
    else if (out_hs && |jumps_q)    tag_active_d = 1'b1;
    else if (branch_resolve)        tag_active_d = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      tag_active_q  <= 1'b0;
      payload_q     <= '0;
      writes_q      <= '0;
      jumps_q       <= '0;
      q_valid_q     <= 1'b0;
      q_rename_q    <= '0;
      q_regs_q      <= '0;
      q_tag_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      out_payload_q <= '0;
      out_regs_q    <= '0;
      out_tag_q     <= '0;
    end else begin
      tag_active_q <= tag_active_d;
      if (flush) begin
        state_q     <= IDLE;
        q_valid_q   <= 1'b0;
        q_rename_q  <= '0;
        out_valid_q <= 1'b0;
      end else begin
        if (ack_ok) begin
          out_payload_q <= payload_q;
          out_regs_q    <= out_regs_d;
          out_tag_q     <= out_tag_d;
          out_valid_q   <= 1'b1;
          q_valid_q     <= 1'b0;
          q_rename_q    <= '0;
          state_q       <= OUT;
        end
        if (out_hs) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        if (accept) begin
          payload_q  <= in_payload;
          writes_q   <= in_writes;
          jumps_q    <= in_jumps;
          q_regs_q   <= in_regs;
          q_rename_q <= q_rename_d;
          q_tag_q    <= tag_active_q;
          q_valid_q  <= 1'b1;
          state_q    <= QUERY;
        end
      end
    end
  end

endmodule

// File: tb/tb_rename_resolver_nway.sv
// Directed bench for rename_resolver_nway: a 2-wide and a 4-wide instance share clock and handshake controls.
module tb_rename_resolver_nway;

  logic clock = 1'b0;
  logic reset, flush, branch_resolve, q_ack, q_full, out_ready;

  logic         a_in_valid, a_in_ready, a_q_valid, a_q_tag, a_out_valid, a_stall;
  logic [191:0] a_in_payload, a_out_payload;
  logic [35:0]  a_in_regs, a_q_regs, a_q_map;
  logic [1:0]   a_in_writes, a_in_jumps, a_q_rename, a_out_tag;
  logic [47:0]  a_out_regs;

  logic         b_in_valid, b_in_ready, b_q_valid, b_q_tag, b_out_valid, b_stall;
  logic [31:0]  b_in_payload, b_out_payload;
  logic [71:0]  b_in_regs, b_q_regs, b_q_map;
  logic [3:0]   b_in_writes, b_in_jumps, b_q_rename, b_out_tag;
  logic [95:0]  b_out_regs;

  int errors = 0;
  int checks = 0;

  logic [35:0]  grp_a, grp_b;
  logic [47:0]  exp_a;
  logic [191:0] pay_a;
  logic [95:0]  exp_b;
  int           cnt;

  always #5 clock = ~clock;

  rename_resolver_nway #(.XLEN(32), .WIDTH(2), .REG_W(6), .PAYLOAD_W(96)) u2 (
    .clock(clock), .reset(reset), .flush(flush), .branch_resolve(branch_resolve),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_payload(a_in_payload),
    .in_regs(a_in_regs), .in_writes(a_in_writes), .in_jumps(a_in_jumps),
    .q_valid(a_q_valid), .q_rename(a_q_rename), .q_regs(a_q_regs), .q_tag(a_q_tag),
    .q_ack(q_ack), .q_full(q_full), .q_map(a_q_map),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_payload(a_out_payload),
    .out_regs(a_out_regs), .out_tag(a_out_tag), .stall(a_stall)
  );

  rename_resolver_nway #(.XLEN(32), .WIDTH(4), .REG_W(6), .PAYLOAD_W(8)) u4 (
    .clock(clock), .reset(reset), .flush(flush), .branch_resolve(branch_resolve),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_payload(b_in_payload),
    .in_regs(b_in_regs), .in_writes(b_in_writes), .in_jumps(b_in_jumps),
    .q_valid(b_q_valid), .q_rename(b_q_rename), .q_regs(b_q_regs), .q_tag(b_q_tag),
    .q_ack(q_ack), .q_full(q_full), .q_map(b_q_map),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_payload(b_out_payload),
    .out_regs(b_out_regs), .out_tag(b_out_tag), .stall(b_stall)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 0; branch_resolve = 0; q_ack = 0; q_full = 0; out_ready = 0;
    a_in_valid = 0; a_in_payload = '0; a_in_regs = '0; a_in_writes = '0; a_in_jumps = '0; a_q_map = '0;
    b_in_valid = 0; b_in_payload = '0; b_in_regs = '0; b_in_writes = '0; b_in_jumps = '0; b_q_map = '0;
    step(); step();
    checks++; if ({a_q_valid, a_out_valid, a_stall, a_q_tag} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=0000", {a_q_valid, a_out_valid, a_stall, a_q_tag}); end
    checks++; if ({a_out_regs, a_out_tag, a_q_regs, a_q_rename} !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", {a_out_regs, a_out_tag, a_q_regs, a_q_rename}); end
    checks++; if ({b_out_valid, b_q_valid, b_stall} !== 3'b0) begin errors++; $display("FAIL reset_wide got=%b exp=000", {b_out_valid, b_q_valid, b_stall}); end
    reset = 1'b0;
    step();
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); end
  endtask

  task automatic test_raw_backpressure();
    grp_a = {6'd6, 6'd7, 6'd5, 6'd5, 6'd1, 6'd2};
    pay_a = {96'h0123_4567_89AB_CDEF_0F1E_2D3C, 96'hFEDC_BA98_7654_3210_A5A5_5A5A};
    a_in_regs = grp_a; a_in_writes = 2'b01; a_in_jumps = 2'b00; a_in_payload = pay_a; a_in_valid = 1;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL raw_in_ready got=%b exp=1", a_in_ready); end
    step();
    a_in_valid = 0;
    checks++; if ({a_q_valid, a_q_rename, a_stall, a_out_valid, a_q_tag} !== 6'b101100) begin errors++; $display("FAIL raw_query got=%b exp=101100", {a_q_valid, a_q_rename, a_stall, a_out_valid, a_q_tag}); end
    checks++; if (a_q_regs !== grp_a) begin errors++; $display("FAIL raw_q_regs got=%h exp=%h", a_q_regs, grp_a); end
    q_ack = 1; a_q_map = {6'd50, 6'd12, 6'd13, 6'd40, 6'd11, 6'd10};
    step();
    q_ack = 0;
    exp_a = {6'd0, 6'd6, 6'd12, 6'd40, 6'd40, 6'd5, 6'd11, 6'd10};
    checks++; if ({a_out_valid, a_q_valid, a_out_tag} !== 4'b1000) begin errors++; $display("FAIL raw_out_ctrl got=%b exp=1000", {a_out_valid, a_q_valid, a_out_tag}); end
    checks++; if (a_out_regs !== exp_a) begin errors++; $display("FAIL raw_out_regs got=%h exp=%h", a_out_regs, exp_a); end
    checks++; if (a_out_payload !== pay_a) begin errors++; $display("FAIL raw_payload got=%h exp=%h", a_out_payload, pay_a); end
    a_q_map = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if ({a_out_valid, a_stall, a_out_regs, a_out_payload} !== {1'b1, 1'b1, exp_a, pay_a}) begin errors++; $display("FAIL hold_%0d got=%b/%b/%h exp=1/1/%h", k, a_out_valid, a_stall, a_out_regs, exp_a); end
    end
    grp_b = {6'd9, 6'd8, 6'd0, 6'd8, 6'd0, 6'd0};
    a_in_regs = grp_b; a_in_writes = 2'b11; a_in_valid = 1; out_ready = 1;
    #1;
    checks++; if ({a_in_ready, a_stall} !== 2'b10) begin errors++; $display("FAIL b2b_ready got=%b exp=10", {a_in_ready, a_stall}); end
    step();
    a_in_valid = 0; out_ready = 0;
    checks++; if ({a_out_valid, a_q_valid, a_q_rename} !== 4'b0111) begin errors++; $display("FAIL b2b_query got=%b exp=0111", {a_out_valid, a_q_valid, a_q_rename}); end
    checks++; if (a_q_regs !== grp_b) begin errors++; $display("FAIL b2b_q_regs got=%h exp=%h", a_q_regs, grp_b); end
  endtask

  task automatic test_retry();
    q_ack = 1; q_full = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if ({a_q_valid, a_stall, a_out_valid, a_q_regs} !== {3'b110, grp_b}) begin errors++; $display("FAIL retry_%0d got=%b%b%b %h exp=110 %h", k, a_q_valid, a_stall, a_out_valid, a_q_regs, grp_b); end
    end
    q_full = 0; a_q_map = {6'd21, 6'd3, 6'd4, 6'd20, 6'd1, 6'd2};
    step();
    q_ack = 0;
    exp_a = {6'd21, 6'd9, 6'd20, 6'd4, 6'd20, 6'd8, 6'd1, 6'd2};
    checks++; if ({a_out_valid, a_out_regs} !== {1'b1, exp_a}) begin errors++; $display("FAIL retry_out got=%b %h exp=1 %h", a_out_valid, a_out_regs, exp_a); end
    out_ready = 1;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (a_out_valid) cnt++;
    end
    checks++; if (cnt !== 0 || a_q_valid !== 1'b0) begin errors++; $display("FAIL retry_single got=%0d extra groups exp=0", cnt); end
  endtask

  task automatic test_tags();
    a_in_regs = '0; a_in_writes = 2'b00; a_in_jumps = 2'b01; a_in_valid = 1; a_q_map = '0;
    step();
    a_in_valid = 0; q_ack = 1;
    step();
    q_ack = 0;
    checks++; if ({a_out_valid, a_out_tag} !== 3'b110) begin errors++; $display("FAIL tag_jump got=%b exp=110", {a_out_valid, a_out_tag}); end
    a_in_jumps = 2'b00; a_in_valid = 1;
    step();
    a_in_valid = 0; q_ack = 1;
    step();
    q_ack = 0;
    checks++; if (a_out_tag !== 2'b11) begin errors++; $display("FAIL tag_spec got=%b exp=11", a_out_tag); end
    a_in_jumps = 2'b10; a_in_valid = 1;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL tag_block_out got=%b exp=0", a_in_ready); end
    step(); step();
    checks++; if ({a_in_ready, a_q_valid} !== 2'b00) begin errors++; $display("FAIL tag_block_idle got=%b exp=00", {a_in_ready, a_q_valid}); end
    branch_resolve = 1;
    step();
    branch_resolve = 0;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL tag_resolve got=%b exp=1", a_in_ready); end
    step();
    a_in_valid = 0;
    checks++; if ({a_q_valid, a_q_tag} !== 2'b10) begin errors++; $display("FAIL tag_q_tag got=%b exp=10", {a_q_valid, a_q_tag}); end
    q_ack = 1;
    step();
    q_ack = 0;
    checks++; if (a_out_tag !== 2'b00) begin errors++; $display("FAIL tag_clear got=%b exp=00", a_out_tag); end
    step();
  endtask

  task automatic test_flush();
    a_in_jumps = 2'b00; a_in_valid = 1;
    step();
    a_in_valid = 0;
    checks++; if (a_q_valid !== 1'b1) begin errors++; $display("FAIL flush_pre got=%b exp=1", a_q_valid); end
    flush = 1; q_ack = 1; q_full = 0;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b exp=0", a_in_ready); end
    step();
    flush = 0; q_ack = 0;
    checks++; if ({a_q_valid, a_out_valid, a_stall} !== 3'b000) begin errors++; $display("FAIL flush_clear got=%b exp=000", {a_q_valid, a_out_valid, a_stall}); end
    a_in_jumps = 2'b01; a_in_valid = 1;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL flush_tag got=%b exp=1", a_in_ready); end
    a_in_valid = 0;
    step();
    checks++; if ({a_out_valid, a_q_valid} !== 2'b00) begin errors++; $display("FAIL flush_after got=%b exp=00", {a_out_valid, a_q_valid}); end
  endtask

  task automatic test_wide();
    out_ready = 1;
    b_in_regs = {6'd0, 6'd5, 6'd3, 6'd3, 6'd0, 6'd0, 6'd0, 6'd0, 6'd3, 6'd3, 6'd0, 6'd0};
    b_in_writes = 4'b0111; b_in_jumps = 4'b0000; b_in_payload = 32'hCAFE_F00D; b_in_valid = 1;
    step();
    b_in_valid = 0;
    checks++; if ({b_q_valid, b_q_rename} !== 5'b10101) begin errors++; $display("FAIL wide_rename got=%b exp=10101", {b_q_valid, b_q_rename}); end
    q_ack = 1;
    b_q_map = {6'd60, 6'd9, 6'd10, 6'd35, 6'd7, 6'd8, 6'd50, 6'd5, 6'd6, 6'd33, 6'd1, 6'd2};
    step();
    q_ack = 0;
    exp_b = {6'd0, 6'd0, 6'd9, 6'd35, 6'd35, 6'd3, 6'd7, 6'd8, 6'd0, 6'd0, 6'd5, 6'd33, 6'd33, 6'd3, 6'd1, 6'd2};
    checks++; if (b_out_regs !== exp_b) begin errors++; $display("FAIL wide_regs got=%h exp=%h", b_out_regs, exp_b); end
    checks++; if ({b_out_valid, b_out_tag, b_out_payload} !== {5'b10000, 32'hCAFE_F00D}) begin errors++; $display("FAIL wide_out got=%b %b %h exp=1 0000 cafef00d", b_out_valid, b_out_tag, b_out_payload); end
    step();
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL wide_done got=%b exp=0", b_out_valid); end
  endtask

  task automatic test_reset_mid_out();
    out_ready = 0;
    a_in_regs = {6'd2, 6'd1, 6'd1, 6'd1, 6'd0, 6'd0}; a_in_writes = 2'b11; a_in_jumps = 2'b00; a_in_valid = 1;
    step();
    a_in_valid = 0; q_ack = 1; a_q_map = {6'd30, 6'd31, 6'd32, 6'd33, 6'd34, 6'd35};
    step();
    q_ack = 0;
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got=%b exp=1", a_out_valid); end
    #2 reset = 1;
    #1;
    checks++; if ({a_out_valid, a_q_valid, a_stall, a_out_regs, a_out_tag, a_out_payload} !== '0) begin errors++; $display("FAIL areset_clear got=%b%b%b %h exp=000 0", a_out_valid, a_q_valid, a_stall, a_out_regs); end
    reset = 0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test sequence");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_raw_backpressure();
    test_retry();
    test_tags();
    test_flush();
    test_wide();
    test_reset_mid_out();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rename_resolver_nway.md
Name: rename_resolver_nway

Overview:
Parametrised N-wide dependency resolver and rename requester between the decoder and the issue/dispatch stage. It accepts a group of WIDTH decoded instructions and requests physical registers from the rename table through a query handshake. It resolves intra-group RAW dependencies, assigns speculation tags, and presents the renamed group downstream with valid/ready. Unlike the 2-wide predecessor, it supports retry on rename-table exhaustion, backpressure, flush, and branch-resolution tag clearing.

Parameters:
XLEN, 32, data/address width (payload sizing only)
WIDTH, 2, instructions per group (1..8)
REG_W, 6, register index width; index 0 is the hard-zero register
PAYLOAD_W, 96, opaque per-instruction payload (address, immediate, name, type, flags) passed through unchanged

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous pipeline flush
branch_resolve  in  1  pulse: outstanding speculative branch resolved
in_valid  in  1  input group valid
in_ready  out  1  group accepted when in_valid&&in_ready
in_payload  in  WIDTH*PAYLOAD_W  per-slot pass-through payload
in_regs  in  WIDTH*3*REG_W  per slot {rd,rs2,rs1}, slot 0 at LSBs
in_writes  in  WIDTH  slot writes rd
in_jumps  in  WIDTH  slot is a jump/branch
q_valid  out  1  rename query active
q_rename  out  WIDTH  slot requests a new physical register
q_regs  out  WIDTH*3*REG_W  registered copy of in_regs of the held group
q_tag  out  1  tag_active at query time
q_ack  in  1  rename table response valid (same or later cycle)
q_full  in  1  with q_ack: insufficient free registers, nothing allocated
q_map  in  WIDTH*3*REG_W  per slot {rn,rs2_map,rs1_map}
out_valid  out  1  renamed group valid
out_ready  in  1  downstream accepts
out_payload  out  WIDTH*PAYLOAD_W  payload of held group
out_regs  out  WIDTH*4*REG_W  per slot {rn,rd,rs2,rs1}
out_tag  out  WIDTH  per-slot speculation tag
stall  out  1  high in QUERY and in OUT while !out_ready; stalls the loader/decoder

Behaviour:
- Reset (async): state=IDLE; tag_active=0; q_valid=0, q_rename=0, q_regs=0, q_tag=0, out_valid=0, out_payload=0, out_regs=0, out_tag=0, stall=0.
- FSM: IDLE, QUERY, OUT.
- in_ready=(IDLE || (OUT && out_ready)) && !(tag_active && |in_jumps) && !flush. A jump group while a branch is outstanding waits for branch_resolve.
- Accept: latch payload, regs, writes, jumps; next cycle QUERY, q_valid=1, q_rename[j]=writes[j]&&rd[j]!=0, q_tag=tag_active.
- QUERY: hold q_* stable until q_ack. q_ack&&q_full: stay in QUERY and re-query the next cycle; no output. q_ack&&!q_full: register outputs, q_valid=0, q_rename=0, next OUT, out_valid=1. Minimum latency from accept to out_valid is 2 cycles.
- Resolution for slot j, src s: if some i<j has writes[i], rd[i]!=0 and rd[i]==s, use rn[i] of the highest such i; else s_map[j]. Source index 0 never matches. rn out = q_map rn if writes&&rd!=0, else 0. rd passes unchanged.
- Tags: out_tag[j]=0 if jumps[j]; else 1 if any jumps[i<j]; else tag_active.
- tag_active: set on output handshake of a group with |jumps; cleared on branch_resolve. If both happen in the same cycle, set wins.
- OUT: hold all outputs stable while !out_ready. On handshake, go to QUERY if an input is accepted the same cycle, else IDLE (out_valid=0).
- flush: highest priority after reset. Next state IDLE; q_valid, out_valid, stall and tag_active cleared; held group dropped. A q_ack in the flush cycle is ignored.

Test Plan:
- WIDTH=2, slot0 add rd=5, slot1 rs1=5 rs2=7, q_map rn0=40, rs2_map1=12 -> slot1 out rs1=40, rs2=12; out_valid 2 cycles after accept.
- WIDTH=4, slots 0 and 2 both write rd=3 (rn 33, 35); slot3 rs1=3 -> 35; slot1 rs1=3 -> 33; rd=0 writer yields rn=0 and q_rename=0.
- q_ack with q_full for 3 cycles then clean ack -> q_regs stable, stall high throughout, exactly one output group.
- Group jumps=0b01 (WIDTH=2) -> out_tag=0b10, tag_active=1; next jump group gets in_ready=0 until branch_resolve pulse.
- out_ready low 4 cycles -> outputs stable; back-to-back input accepted in the handshake cycle.
- flush during QUERY with simultaneous q_ack -> no out_valid, state IDLE, tag_active=0; async reset mid-OUT clears all outputs immediately.
